rom_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported, combinational boot ROM. Shares the ROM between the instruction-fetch port (port 0) and the load port (port 1). Checks alignment and range on each granted access, registers the read data, and returns a one-cycle response pulse. Sits between the core's fetch/LSU request interfaces and the ROM's `addr_i`/`cs_i`/`hb_i`/`rdata_o` pins.

---
 rtl/rom_pkg.sv | 29 ++
 rtl/rom_arbiter_if.sv | 30 +++
 rtl/rom_arb_pick.sv | 15 +
 rtl/rom_arbiter.sv | 102 ++++++++++
 tb/tb_rom_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/rom_pkg.sv
// rom_pkg: shared constants for the boot-ROM arbiter.
//   HB_* : access-size encodings on hb (11 also decodes as word)
//   ROM_WORDS_DEFAULT : default ROM depth in 32-bit words
//   PORT_IF / PORT_LS : port indices (fetch / load)
//   misaligned() : alignment rule for one access size
package rom_pkg;

    localparam logic [1:0] HB_BYTE = 2'b01;
    localparam logic [1:0] HB_HALF = 2'b10;
    localparam logic [1:0] HB_WORD = 2'b00;

    localparam int ROM_WORDS_DEFAULT = 256;

    localparam int PORT_IF = 0;
    localparam int PORT_LS = 1;

    // Bytes never misalign; halfwords need addr[0]=0; word (00 or 11) needs addr[1:0]=0.
    function automatic logic misaligned(input logic [1:0] lsb, input logic [1:0] hb);
        logic m;
        case (hb)
            HB_BYTE: m = 1'b0;
            HB_HALF: m = lsb[0];
            HB_WORD: m = |lsb;
            default: m = |lsb;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: bus bundle between the core request ports, the arbiter and the ROM.
//   Core side : req_i, addr0_i/addr1_i, hb0_i/hb1_i -> gnt_o, rvalid_o, rdata_o, err_o
//   ROM side  : rom_addr_o, rom_cs_o, rom_hb_o -> rom_rdata_i
//   slave  modport : the arbiter
//   master modport : the core + ROM environment
interface rom_arbiter_if;
    logic [1:0]  req_i;
    logic [31:0] addr0_i;
    logic [31:0] addr1_i;
    logic [1:0]  hb0_i;
    logic [1:0]  hb1_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] rom_addr_o;
    logic        rom_cs_o;
    logic [1:0]  rom_hb_o;
    logic [31:0] rom_rdata_i;

    modport slave (
        input  req_i, addr0_i, addr1_i, hb0_i, hb1_i, rom_rdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o, rom_addr_o, rom_cs_o, rom_hb_o
    );

    modport master (
        output req_i, addr0_i, addr1_i, hb0_i, hb1_i, rom_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, rom_addr_o, rom_cs_o, rom_hb_o
    );
endinterface

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: combinational 2-way one-hot grant.
//   req : request per port
//   ptr : preferred port, wins when both request
//   gnt : one-hot grant (zero when req is zero)
module rom_arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (req[ptr])       gnt[ptr]  = 1'b1;
        else if (req[~ptr]) gnt[~ptr] = 1'b1;
    end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares a single-ported combinational boot ROM between the fetch
// port (0) and load port (1). Grants one access per cycle, checks alignment and
// range, registers the ROM data and returns a one-cycle rvalid pulse.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : rom_arbiter_if.slave (core request/response + ROM pins)
// Build option: ROM_ARB_RR_EN selects round-robin arbitration; otherwise
// fixed priority with the load port over the fetch port.
module rom_arbiter
    import rom_pkg::*;
#(
    parameter int ROM_WORDS = ROM_WORDS_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    rom_arbiter_if.slave  bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    // 33 bits so a full 4 GiB limit would still compare correctly.
    localparam logic [32:0] ROM_LIMIT = 33'(ROM_WORDS) << 2;

    logic [1:0]  gnt;
    logic        ptr;
    logic        any_gnt;
    logic        err_c;
    logic [0:0]  state, state_nxt;
    logic [1:0]  rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    rom_arb_pick u_pick (
        .req (bus.req_i),
        .ptr (ptr),
        .gnt (gnt)
    );

`ifdef ROM_ARB_RR_EN
    // Pointer flips to the port that did not just win.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      ptr <= 1'(PORT_IF);
        else if (any_gnt) ptr <= gnt[PORT_IF] ? 1'(PORT_LS) : 1'(PORT_IF);
    end
`else
    assign ptr = 1'(PORT_LS);
`endif

    assign any_gnt   = |gnt;
    assign bus.gnt_o = gnt;

    // ROM address/size mux; idle bus is all-zero with chip select low.
    always_comb begin
        bus.rom_addr_o = '0;
        bus.rom_hb_o   = '0;
        bus.rom_cs_o   = 1'b0;
        if (gnt[PORT_LS]) begin
            bus.rom_addr_o = bus.addr1_i;
            bus.rom_hb_o   = bus.hb1_i;
            bus.rom_cs_o   = 1'b1;
        end else if (gnt[PORT_IF]) begin
            bus.rom_addr_o = bus.addr0_i;
            bus.rom_hb_o   = bus.hb0_i;
            bus.rom_cs_o   = 1'b1;
        end
    end

    always_comb begin
        err_c = any_gnt &&
                (misaligned(bus.rom_addr_o[1:0], bus.rom_hb_o) ||
                 ({1'b0, bus.rom_addr_o} >= ROM_LIMIT));
    end

    // State only tracks whether a response is being registered.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|bus.req_i)  state_nxt = ST_RESP;
            ST_RESP: if (!(|bus.req_i)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            rvalid_q <= gnt;
            err_q    <= err_c;
            if (any_gnt) rdata_q <= err_c ? 32'h0 : bus.rom_rdata_i;
        end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: self-checking bench for rom_arbiter (either arbitration build).
// Directed vector table, hand sequences for contention and mid-access reset, and
// a random two-requester run checked against a behavioural model.
module tb_rom_arbiter;
    import rom_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rom_arbiter_if bus ();

    rom_arbiter #(.ROM_WORDS(256)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    logic [31:0] rom [256];
    int tests = 0;
    int fails = 0;

    // Combinational ROM: little-endian lane select, zero-extended.
    always_comb begin
        logic [31:0] w, sh;
        w  = rom[bus.rom_addr_o[9:2]];
        sh = w >> {bus.rom_addr_o[1:0], 3'b000};
        case (bus.rom_hb_o)
            2'b01:   bus.rom_rdata_i = {24'h0, sh[7:0]};
            2'b10:   bus.rom_rdata_i = {16'h0, sh[15:0]};
            default: bus.rom_rdata_i = w;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result of one access, from the address rules directly.
    task automatic model_access(input logic [31:0] a, input logic [1:0] hb,
                                output logic [31:0] d, output logic e);
        longint unsigned ua;
        logic [31:0] w;
        ua = a;
        e = (ua >= 1024) || (hb == 2'b10 && ua % 2 != 0) ||
            ((hb == 2'b00 || hb == 2'b11) && ua % 4 != 0);
        w = rom[(ua / 4) % 256];
        case (hb)
            2'b01:   d = (w >> (8 * (ua % 4))) & 32'hFF;
            2'b10:   d = (w >> (8 * (ua % 4))) & 32'hFFFF;
            default: d = w;
        endcase
        if (e) d = 32'h0;
    endtask

    task automatic drive(input logic [1:0] r, input logic [31:0] a0, input logic [1:0] h0,
                         input logic [31:0] a1, input logic [1:0] h1);
        bus.req_i = r; bus.addr0_i = a0; bus.hb0_i = h0; bus.addr1_i = a1; bus.hb1_i = h1;
    endtask

    task automatic do_reset();
        drive(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_gnt", bus.gnt_o, 0);
        check("rst_cs", bus.rom_cs_o, 0);
        check("rst_rvalid", bus.rvalid_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_rdata", bus.rdata_o, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [1:0]  h0;
        logic [31:0] a1;
        logic [1:0]  h1;
        logic [1:0]  gnt;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [1:0]  act_r;
        logic [31:0] ra [2];
        logic [1:0]  rh [2];
        logic        pref;
        logic [1:0]  mg, pv;
        logic [31:0] ed, md;
        logic        pe, me;
        int          w;

        for (int i = 0; i < 256; i++) rom[i] = (i * 32'h0101_0101) ^ 32'h5A00_0000;
        rom[4] = 32'hDEAD_BEEF;

        vt[0]  = '{2'b01, 32'h10, 2'b00, 32'h0, 2'b00, 2'b01, 32'hDEAD_BEEF, 1'b0};
        vt[1]  = '{2'b10, 32'h0, 2'b00, 32'h13, 2'b01, 2'b10, 32'h0000_00DE, 1'b0};
        vt[2]  = '{2'b10, 32'h0, 2'b00, 32'h11, 2'b10, 2'b10, 32'h0, 1'b1};
        vt[3]  = '{2'b01, 32'h400, 2'b00, 32'h0, 2'b00, 2'b01, 32'h0, 1'b1};
        vt[4]  = '{2'b01, 32'h12, 2'b10, 32'h0, 2'b00, 2'b01, 32'h0000_DEAD, 1'b0};
        vt[5]  = '{2'b10, 32'h0, 2'b00, 32'h10, 2'b11, 2'b10, 32'hDEAD_BEEF, 1'b0};
        vt[6]  = '{2'b01, 32'h3FC, 2'b00, 32'h0, 2'b00, 2'b01, 32'hA5FF_FFFF, 1'b0};
        vt[7]  = '{2'b01, 32'h3FF, 2'b01, 32'h0, 2'b00, 2'b01, 32'h0000_00A5, 1'b0};
        vt[8]  = '{2'b10, 32'h0, 2'b00, 32'hFFFF_FFFC, 2'b00, 2'b10, 32'h0, 1'b1};
        vt[9]  = '{2'b01, 32'h12, 2'b00, 32'h0, 2'b00, 2'b01, 32'h0, 1'b1};
        vt[10] = '{2'b10, 32'h0, 2'b00, 32'h11, 2'b01, 2'b10, 32'h0000_00BE, 1'b0};

        drive(2'b00, 0, 0, 0, 0);
        do_reset();

        // Directed single-port vectors; first one also covers grant right after release.
        foreach (vt[i]) begin
            drive(vt[i].req, vt[i].a0, vt[i].h0, vt[i].a1, vt[i].h1);
            @(negedge clk);
            check($sformatf("v%0d_gnt", i), bus.gnt_o, vt[i].gnt);
            check($sformatf("v%0d_cs", i), bus.rom_cs_o, 1);
            @(posedge clk); #1;
            bus.req_i = 2'b00;
            @(negedge clk);
            check($sformatf("v%0d_rvalid", i), bus.rvalid_o, vt[i].gnt);
            check($sformatf("v%0d_rdata", i), bus.rdata_o, vt[i].data);
            check($sformatf("v%0d_err", i), bus.err_o, vt[i].err);
            check($sformatf("v%0d_idle_cs", i), bus.rom_cs_o, 0);
            check($sformatf("v%0d_idle_addr", i), bus.rom_addr_o, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("hold_rvalid", bus.rvalid_o, 0);
        check("hold_rdata", bus.rdata_o, 32'h0000_00BE);
        @(posedge clk); #1;

        // Contention: both ports requesting for four cycles.
        do_reset();
        drive(2'b11, 32'h10, 2'b00, 32'h13, 2'b01);
        pv = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef ROM_ARB_RR_EN
            mg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            mg = 2'b10;
`endif
            check($sformatf("cont%0d_gnt", k), bus.gnt_o, mg);
            check($sformatf("cont%0d_rvalid", k), bus.rvalid_o, pv);
            if (pv != 0)
                check($sformatf("cont%0d_rdata", k), bus.rdata_o,
                      pv[1] ? 32'h0000_00DE : 32'hDEAD_BEEF);
            pv = mg;
            @(posedge clk); #1;
        end
        bus.req_i = 2'b01;
        @(negedge clk);
        check("cont_p0_gnt", bus.gnt_o, 2'b01);
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        @(posedge clk); #1;

        // Reset in the cycle a response is showing and another grant is being taken.
        do_reset();
        drive(2'b01, 32'h10, 2'b00, 32'h0, 2'b00);
        @(negedge clk);
        check("mid_gnt", bus.gnt_o, 2'b01);
        @(posedge clk); #1;
        check("mid_rvalid_pre", bus.rvalid_o, 2'b01);
        rst_n = 1'b0;
        #1;
        check("mid_rvalid_async", bus.rvalid_o, 0);
        check("mid_rdata_async", bus.rdata_o, 0);
        bus.req_i = 2'b00;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_no_resp", bus.rvalid_o, 0);
        bus.req_i = 2'b11;
        #1;
`ifdef ROM_ARB_RR_EN
        check("mid_ptr_gnt", bus.gnt_o, 2'b01);
`else
        check("mid_ptr_gnt", bus.gnt_o, 2'b10);
`endif
        bus.req_i = 2'b00;
        @(posedge clk); #1;

        // Random run: each requester holds its access until the model grants it.
        do_reset();
        act_r = 2'b00; pref = 1'b0; pv = 2'b00; ed = 32'h0; pe = 1'b0;
        ra[0] = 0; ra[1] = 0; rh[0] = 0; rh[1] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!act_r[p] && ($urandom % 3 != 0)) begin
                    act_r[p] = 1'b1;
                    ra[p] = ($urandom % 8 == 0) ? $urandom : $urandom_range(0, 1023);
                    rh[p] = 2'($urandom);
                end
            end
            drive(act_r, ra[0], rh[0], ra[1], rh[1]);
            if (act_r == 2'b11) begin
`ifdef ROM_ARB_RR_EN
                w = int'(pref);
`else
                w = 1;
`endif
            end else if (act_r[1]) w = 1;
            else if (act_r[0])     w = 0;
            else                   w = -1;
            mg = (w < 0) ? 2'b00 : (2'b01 << w);
            @(negedge clk);
            check("rnd_gnt", bus.gnt_o, mg);
            check("rnd_rvalid", bus.rvalid_o, pv);
            check("rnd_rdata", bus.rdata_o, ed);
            check("rnd_err", bus.err_o, pe);
            pv = mg;
            if (w >= 0) begin
                model_access(ra[w], rh[w], md, me);
                ed = md; pe = me;
                act_r[w] = 1'b0;
                pref = (w == 0);
            end else begin
                pe = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
